// File: rtl/vga_timing_ctrl.sv
// Free-running clock divider plus 640x480@60Hz VGA timing core on a single clock.
// Define VGA_TEST_PATTERN_EN to replace d_in with eight vertical colour bars.
module vga_timing_ctrl #(
  parameter int unsigned DIV_LOG2 = 2,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] clkdiv,
  output logic        pix_tick,
  input  logic [11:0] d_in,
  output logic [8:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        video_on,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  localparam int unsigned H_W         = 10;
  localparam int unsigned V_W         = 10;
  localparam int unsigned ROW_W       = 9;
  localparam int unsigned COL_W       = 10;
  localparam int unsigned RGB_W       = 12;
  localparam int unsigned H_SYNC_END  = 95;
  localparam int unsigned H_VIS_FIRST = 143;
  localparam int unsigned H_VIS_LAST  = 782;
  localparam int unsigned V_SYNC_END  = 1;
  localparam int unsigned V_VIS_FIRST = 35;
  localparam int unsigned V_VIS_LAST  = 514;

  logic [H_W-1:0]   h_count;
  logic [V_W-1:0]   v_count;
  logic             h_last;
  logic             v_last;
  logic             raw_hs;
  logic             raw_vs;
  logic             active;
  logic [RGB_W-1:0] pix_src;

  // Free-running divider; pix_tick marks the last clk of each pixel period
  always_ff @(posedge clk) begin
    if (rst) clkdiv <= '0;
    else     clkdiv <= clkdiv + 32'd1;
  end

  assign pix_tick = &clkdiv[DIV_LOG2-1:0];

  assign h_last = (h_count == H_W'(H_TOTAL - 1));
  assign v_last = (v_count == V_W'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h_count <= '0;
        v_count <= v_last ? '0 : v_count + V_W'(1);
      end else begin
        h_count <= h_count + H_W'(1);
      end
    end
  end

  assign raw_hs = (h_count > H_W'(H_SYNC_END));
  assign raw_vs = (v_count > V_W'(V_SYNC_END));
  assign active = (h_count >= H_W'(H_VIS_FIRST)) && (h_count <= H_W'(H_VIS_LAST)) &&
                  (v_count >= V_W'(V_VIS_FIRST)) && (v_count <= V_W'(V_VIS_LAST));

`ifdef VGA_TEST_PATTERN_EN
  // Eight 80-column bars keyed on the address the current video_on belongs to
  localparam int unsigned BAR_COLS = 80;
  logic [2:0] bar;
  logic       unused_d_in;
  assign bar         = 3'(col_addr / COL_W'(BAR_COLS));
  assign pix_src     = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
  assign unused_d_in = ^d_in;
`else
  assign pix_src = d_in;
`endif

  // Sync, address and colour pipeline; colour uses the previous video_on
  always_ff @(posedge clk) begin
    if (rst) begin
      hs        <= 1'b0;
      vs        <= 1'b0;
      video_on  <= 1'b0;
      col_addr  <= '0;
      row_addr  <= '0;
      {r, g, b} <= '0;
    end else if (pix_tick) begin
      hs        <= raw_hs;
      vs        <= raw_vs;
      video_on  <= active;
      col_addr  <= COL_W'(h_count - H_W'(H_VIS_FIRST));
      row_addr  <= ROW_W'(v_count - V_W'(V_VIS_FIRST));
      {r, g, b} <= video_on ? pix_src : RGB_W'(0);
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl: directed expected vectors keyed on pixel-tick index.
module tb_vga_timing_ctrl;

  // Shortened frame and a clk/2 pixel rate keep a full frame plus a restart short
  localparam int unsigned DIV_LOG2 = 1;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 37;

  logic        clk;
  logic        rst;
  logic [11:0] d_in;
  logic [31:0] clkdiv;
  logic        pix_tick;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        video_on;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;

  vga_timing_ctrl #(
    .DIV_LOG2(DIV_LOG2),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clkdiv  (clkdiv),
    .pix_tick(pix_tick),
    .d_in    (d_in),
    .row_addr(row_addr),
    .col_addr(col_addr),
    .video_on(video_on),
    .hs      (hs),
    .vs      (vs),
    .r       (r),
    .g       (g),
    .b       (b)
  );

  typedef struct {
    int          epoch;
    int          k;
    logic        hs;
    logic        vs;
    logic        vid;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   stim_k   = 0;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int ep, input int k, input logic h, input logic v, input logic vid,
                      input int row, input int col, input logic [11:0] rgb);
    exp_t e;
    e.epoch = ep;
    e.k     = k;
    e.hs    = h;
    e.vs    = v;
    e.vid   = vid;
    e.row   = 9'(row);
    e.col   = 10'(col);
    e.rgb   = rgb;
    sb_q.push_back(e);
  endtask

  // Reset state and the first lines after any reset
  task automatic push_common(input int ep);
    push(ep,    0, 0, 0, 0,   0,    0, 12'h000);
    push(ep,    1, 0, 0, 0, 477,  881, 12'h000);
    push(ep,   96, 0, 0, 0, 477,  976, 12'h000);
    push(ep,   97, 1, 0, 0, 477,  977, 12'h000);
    push(ep,  100, 1, 0, 0, 477,  980, 12'h000);
    push(ep,  800, 1, 0, 0, 477,  656, 12'h000);
    push(ep,  801, 0, 0, 0, 478,  881, 12'h000);
    push(ep, 1601, 0, 1, 0, 479,  881, 12'h000);
    push(ep, 1744, 1, 1, 0, 479,    0, 12'h000);
  endtask

  task automatic push_visible();
    push(1, 28143, 1, 1, 0,   0, 1023, 12'h000);
    push(1, 28144, 1, 1, 1,   0,    0, 12'h000);
    push(1, 28145, 1, 1, 1,   0,    1, 12'hF00);
    push(1, 28400, 1, 1, 1,   0,  256, 12'hF00);
    push(1, 28401, 1, 1, 1,   0,  257, 12'h0F0);
    push(1, 28783, 1, 1, 1,   0,  639, 12'h0F0);
    push(1, 28784, 1, 1, 0,   0,  640, 12'h0F0);
    push(1, 28785, 1, 1, 0,   0,  641, 12'h000);
    push(1, 28944, 1, 1, 1,   1,    0, 12'h000);
    push(1, 29001, 1, 1, 1,   1,   57, 12'h00F);
    push(1, 29600, 1, 1, 0,   1,  656, 12'h000);
    push(1, 29601, 0, 0, 0, 477,  881, 12'h000);
  endtask

  // Advance the stimulus side to a given pixel-tick count, bounded per tick
  task automatic wait_until_tick(input int target);
    while (stim_k < target) begin
      int guard;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!pix_tick && guard < 16);
      if (!pix_tick) begin
        checks++;
        failures++;
        $display("FAIL pix_tick_wait actual=none_in_16_clk required=pulse at tick %0d", stim_k + 1);
        report();
        $finish;
      end
      @(posedge clk);
      #1;
      stim_k++;
    end
  endtask

  // Monitor state
  int   epoch = 0;
  int   mk    = 0;
  int   cyc   = 0;
  logic armed    = 1'b0;
  logic in_reset = 1'b0;
  logic nxt_rst  = 1'b0;
  logic nxt_tick = 1'b0;
  logic hs_q     = 1'b0;
  logic vs_q     = 1'b0;
  int   hs_low   = 0;
  int   vs_low   = 0;
  int   last_hfall = -1;

  task automatic score();
    logic [33:0] act_v;
    logic [33:0] exp_v;
    while (sb_q.size() > 0 &&
           (sb_q[0].epoch < epoch || (sb_q[0].epoch == epoch && sb_q[0].k < mk))) begin
      checks++;
      failures++;
      $display("FAIL vec_missed actual=not_seen required=ep%0d tick %0d", sb_q[0].epoch, sb_q[0].k);
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].epoch == epoch && sb_q[0].k == mk) begin
      act_v = {hs, vs, video_on, row_addr, col_addr, r, g, b};
      exp_v = {sb_q[0].hs, sb_q[0].vs, sb_q[0].vid, sb_q[0].row, sb_q[0].col, sb_q[0].rgb};
      checks++;
      if (act_v != exp_v) begin
        failures++;
        $display("FAIL vec ep%0d k=%0d actual hs=%0b vs=%0b vid=%0b row=%0d col=%0d rgb=%03h required hs=%0b vs=%0b vid=%0b row=%0d col=%0d rgb=%03h",
                 epoch, mk, hs, vs, video_on, row_addr, col_addr, {r, g, b},
                 sb_q[0].hs, sb_q[0].vs, sb_q[0].vid, sb_q[0].row, sb_q[0].col, sb_q[0].rgb);
      end
      void'(sb_q.pop_front());
    end
  endtask

  task automatic sync_checks();
    if (!hs_q && hs) begin
      chk("hs_low_width", hs_low, 96);
      hs_low = 0;
    end
    if (hs_q && !hs) begin
      if (last_hfall >= 0) chk("hs_period", mk - last_hfall, 800);
      last_hfall = mk;
    end
    if (!hs) hs_low++;
    hs_q = hs;
    if (!vs_q && vs) begin
      chk("vs_low_width", vs_low, 1600);
      vs_low = 0;
    end
    if (!vs) vs_low++;
    vs_q = vs;
  endtask

  // Each negedge scores the posedge just passed, then latches what the next edge will see
  always @(negedge clk) begin
    if (armed) begin
      if (nxt_rst) begin
        if (!in_reset) begin
          epoch++;
          in_reset   = 1'b1;
          mk         = 0;
          hs_q       = 1'b0;
          vs_q       = 1'b0;
          hs_low     = 0;
          vs_low     = 0;
          last_hfall = -1;
          score();
        end
        cyc = 0;
      end else begin
        in_reset = 1'b0;
        cyc++;
        if (nxt_tick) begin
          mk++;
          score();
          sync_checks();
        end
      end
      if (epoch > 0 && cyc < 32) begin
        chk("clkdiv", clkdiv, cyc);
        chk("pix_tick", pix_tick, (cyc % 2) == 1);
      end
    end
    nxt_rst  = rst;
    nxt_tick = pix_tick;
    armed    = 1'b1;
  end

  initial begin
    rst  = 1'b1;
    d_in = 12'hF00;
    push_common(1);
    push_visible();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    stim_k = 0;

    wait_until_tick(28400);
    d_in = 12'h0F0;
    wait_until_tick(29000);
    d_in = 12'h00F;
    wait_until_tick(31300);

    // One-clk reset mid-frame (line 2); timing must restart from h=0, v=0
    push_common(2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    stim_k = 0;
    wait_until_tick(1750);

    repeat (4) @(negedge clk);
    chk("scoreboard_leftover", sb_q.size(), 0);
    report();
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    report();
    $finish;
  end

endmodule
